fft_radix2_iterative: RTL and testbench

//  Parametrised N-point radix-2 DIT FFT/IFFT engine. Successor to the fixed 8-point, 3-stage FFT top.

---
 rtl/fft_pkg.sv | 34 +++
 rtl/fft_radix2_iterative_if.sv | 24 ++
 rtl/fft_radix2_iterative_butterfly.sv | 37 +++
 rtl/fft_radix2_iterative.sv | 144 ++++++++++++++
 tb/tb_fft_radix2_iterative.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the iterative radix-2 FFT engine.
// Sample/bin width is fixed here so the complex type can be shared across files.
package fft_pkg;
    localparam int DATA_W = 12;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_UNLOAD} state_e;

    function automatic int unsigned bitrev(input int unsigned v, input int unsigned bits);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 32'd1);
        return r;
    endfunction

    // cos or sin of 2*pi*idx/n, integer Taylor series in Q28, rounded to Q2.(tw_w-2).
    function automatic int twiddle(input int idx, input int n, input int tw_w, input bit want_sin);
        longint x, x2, term, acc;
        x    = (64'sd1686629713 * longint'(idx)) / longint'(n);
        x2   = (x * x) >>> 28;
        term = want_sin ? x : (64'sd1 <<< 28);
        acc  = term;
        for (int k = 1; k < 14; k++) begin
            if (want_sin) term = -((term * x2) >>> 28) / longint'((2 * k) * (2 * k + 1));
            else          term = -((term * x2) >>> 28) / longint'((2 * k - 1) * (2 * k));
            acc = acc + term;
        end
        return int'(((acc <<< (tw_w - 2)) + (64'sd1 <<< 27)) >>> 28);
    endfunction
endpackage

// File: rtl/fft_radix2_iterative_if.sv
// Sample-in / bin-out streaming bus of the FFT engine.
interface fft_if #(parameter int N_POINTS = 8);
    import fft_pkg::*;
    localparam int S = $clog2(N_POINTS);

    logic         in_valid;
    logic         in_ready;
    logic         in_inverse;
    cplx_t        in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    cplx_t        out_data;
    logic [S-1:0] out_index;

    modport master (
        output in_valid, in_data, in_inverse, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
    );
    modport slave (
        input  in_valid, in_data, in_inverse, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/fft_radix2_iterative_butterfly.sv
// Combinational radix-2 DIT butterfly; each output is halved so a stage never grows.
module fft_butterfly
    import fft_pkg::*;
#(
    parameter int TW_W = 12
) (
    input  cplx_t                  a_i,
    input  cplx_t                  b_i,
    input  logic signed [TW_W-1:0] w_re_i,
    input  logic signed [TW_W-1:0] w_im_i,
    output cplx_t                  top_o,
    output cplx_t                  bot_o
);
    localparam int PW = DATA_W + TW_W + 2;

    logic signed [PW-1:0] ar, ai, br, bi, wr, wi, pr, pim, tr, ti, lr, li;

    // The low DATA_W bits of the halved sum do not depend on the extra headroom bits.
    always_comb begin
        ar  = PW'($signed(a_i.re));
        ai  = PW'($signed(a_i.im));
        br  = PW'($signed(b_i.re));
        bi  = PW'($signed(b_i.im));
        wr  = PW'(w_re_i);
        wi  = PW'(w_im_i);
        pr  = (br * wr - bi * wi) >>> (TW_W - 2);
        pim = (br * wi + bi * wr) >>> (TW_W - 2);
        tr  = (ar + pr) >>> 1;
        ti  = (ai + pim) >>> 1;
        lr  = (ar - pr) >>> 1;
        li  = (ai - pim) >>> 1;
        top_o.re = DATA_W'(tr);
        top_o.im = DATA_W'(ti);
        bot_o.re = DATA_W'(lr);
        bot_o.im = DATA_W'(li);
    end
endmodule

// File: rtl/fft_radix2_iterative.sv
// N-point in-place radix-2 DIT FFT/IFFT: samples in, one butterfly per cycle, bins out in order.
// state      | meaning
// ST_LOAD    | accept N samples into the bank at bit-reversed addresses
// ST_COMPUTE | S stages x N/2 butterflies, one per cycle
// ST_UNLOAD  | present bank[k] in natural order, k advances on handshake
module fft_radix2_iterative
    import fft_pkg::*;
#(
    parameter int N_POINTS = 8,
    parameter int TW_W     = 12
) (
    input  logic clk_i,
    input  logic rst_i,
    fft_if.slave bus,
    output logic fft_busy_o,
    output logic fft_finish_o
);
    localparam int S  = $clog2(N_POINTS);
    localparam int H  = N_POINTS / 2;
    localparam int SW = $clog2(S);
    localparam int BW = S - 1;
    localparam logic [S-1:0]  LAST_K = S'(N_POINTS - 1);
    localparam logic [SW-1:0] LAST_S = SW'(S - 1);
    localparam logic [BW-1:0] LAST_B = BW'(H - 1);

    state_e        state_q, state_d;
    logic [S-1:0]  cnt_q, cnt_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [BW-1:0] bfly_q, bfly_d;
    logic          inv_q, inv_d;
    logic          finish_q, finish_d;
    cplx_t         bank_q [N_POINTS];

    logic [S-1:0]           top_a, bot_a, load_a;
    logic [BW-1:0]          tw_a;
    logic signed [TW_W-1:0] rom_cos [H];
    logic signed [TW_W-1:0] rom_sin [H];
    logic signed [TW_W-1:0] w_im;
    cplx_t                  bf_top, bf_bot;
    logic                   unload;

    for (genvar i = 0; i < H; i++) begin : g_rom
        localparam int C  = twiddle(i, N_POINTS, TW_W, 1'b0);
        localparam int SN = twiddle(i, N_POINTS, TW_W, 1'b1);
        assign rom_cos[i] = TW_W'(C);
        assign rom_sin[i] = TW_W'(SN);
    end

    always_comb begin
        int unsigned s, b, half;
        s      = 32'(stage_q);
        b      = 32'(bfly_q);
        half   = 32'd1 << s;
        top_a  = S'(((b >> s) << (s + 1)) + (b & (half - 1)));
        bot_a  = S'(32'(top_a) + half);
        tw_a   = BW'((b & (half - 1)) << (BW - s));
        load_a = S'(bitrev(32'(cnt_q), S));
    end

    // Forward transform uses W = cos - j*sin, the inverse the conjugate.
    assign w_im = inv_q ? rom_sin[tw_a] : -rom_sin[tw_a];

    fft_butterfly #(.TW_W(TW_W)) u_bfly (
        .a_i   (bank_q[top_a]),
        .b_i   (bank_q[bot_a]),
        .w_re_i(rom_cos[tw_a]),
        .w_im_i(w_im),
        .top_o (bf_top),
        .bot_o (bf_bot)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stage_d  = stage_q;
        bfly_d   = bfly_q;
        inv_d    = inv_q;
        finish_d = 1'b0;
        unique case (state_q)
            ST_LOAD: if (bus.in_valid) begin
                if (cnt_q == '0) inv_d = bus.in_inverse;
                cnt_d = cnt_q + S'(1);
                if (cnt_q == LAST_K) state_d = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                bfly_d = bfly_q + BW'(1);
                if (bfly_q == LAST_B) begin
                    stage_d = stage_q + SW'(1);
                    if (stage_q == LAST_S) begin
                        stage_d = '0;
                        state_d = ST_UNLOAD;
                    end
                end
            end
            ST_UNLOAD: if (bus.out_ready) begin
                cnt_d = cnt_q + S'(1);
                if (cnt_q == LAST_K) begin
                    finish_d = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_LOAD;
            cnt_q    <= '0;
            stage_q  <= '0;
            bfly_q   <= '0;
            inv_q    <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            bfly_q   <= bfly_d;
            inv_q    <= inv_d;
            finish_q <= finish_d;
        end
    end

    // Bank is not reset; a frame always rewrites every entry during LOAD.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == ST_LOAD && bus.in_valid) begin
                bank_q[load_a] <= bus.in_data;
            end else if (state_q == ST_COMPUTE) begin
                bank_q[top_a] <= bf_top;
                bank_q[bot_a] <= bf_bot;
            end
        end
    end

    assign unload        = (state_q == ST_UNLOAD);
    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.out_valid = unload;
    assign bus.out_data  = unload ? bank_q[cnt_q] : '0;
    assign bus.out_index = unload ? cnt_q : '0;
    assign bus.out_last  = unload && (cnt_q == LAST_K);
    assign fft_busy_o    = (state_q == ST_COMPUTE);
    assign fft_finish_o  = finish_q;
endmodule

// File: tb/tb_fft_radix2_iterative.sv
// Scoreboard bench for the FFT engine: floating-point DFT reference, decoupled output monitor.
module tb_fft_radix2_iterative;
    import fft_pkg::*;

    localparam int  N   = 8;
    localparam int  S   = 3;
    localparam real TOL = 3.0;
    localparam real PI  = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, finish;

    fft_if #(.N_POINTS(N)) bus ();

    fft_radix2_iterative #(.N_POINTS(N), .TW_W(12)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .fft_busy_o  (busy),
        .fft_finish_o(finish)
    );

    always #5 clk = ~clk;

    typedef struct {
        real re;
        real im;
        int  idx;
    } exp_t;

    exp_t sb [$];
    int   total = 0;
    int   bad = 0;
    int   frames_exp = 0;
    int   finish_cnt = 0;
    int   rdy_mode = 0;
    int   cur_re [N];
    int   cur_im [N];

    task automatic check(input string name, input bit ok, input string got, input string want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %s, expected %s", name, got, want);
        end
    endtask

    // Reference: X[k]/N with exact trig, sign of the exponent chosen by inv.
    task automatic push_expect(input bit inv);
        for (int k = 0; k < N; k++) begin
            exp_t e;
            real sr, si;
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < N; n++) begin
                real ang, c, s;
                ang = 2.0 * PI * real'(n * k) / real'(N);
                c   = $cos(ang);
                s   = inv ? $sin(ang) : -$sin(ang);
                sr += real'(cur_re[n]) * c - real'(cur_im[n]) * s;
                si += real'(cur_re[n]) * s + real'(cur_im[n]) * c;
            end
            e.re  = sr / real'(N);
            e.im  = si / real'(N);
            e.idx = k;
            sb.push_back(e);
        end
        frames_exp++;
    endtask

    task automatic send_sample(input int re, input int im, input bit inv);
        int guard;
        guard = 0;
        bus.in_valid   = 1'b1;
        bus.in_data.re = DATA_W'(re);
        bus.in_data.im = DATA_W'(im);
        bus.in_inverse = inv;
        while (!bus.in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) check("in_ready_timeout", 1'b0, "no ready", "ready");
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_frame(input bit inv, input bit push, input int gap_max);
        if (push) push_expect(inv);
        for (int n = 0; n < N; n++) begin
            int gap;
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (gap) @(negedge clk);
            send_sample(cur_re[n], cur_im[n], (n == 0) ? inv : 1'($urandom_range(1, 0)));
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || bus.out_valid) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) check("drain_timeout", 1'b0, "bins pending", "all bins out");
        repeat (2) @(negedge clk);
    endtask

    task automatic fill_random();
        for (int n = 0; n < N; n++) begin
            cur_re[n] = int'($urandom_range(1000, 0)) - 500;
            cur_im[n] = int'($urandom_range(1000, 0)) - 500;
        end
    endtask

    initial begin
        int ph;
        ph = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    bus.out_ready = (ph == 0);
                    ph = (ph + 1) % 3;
                end
                2: bus.out_ready = 1'($urandom_range(1, 0));
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard pops, hold-while-stalled, finish pulse and busy length.
    initial begin
        cplx_t        held;
        logic [S-1:0] held_idx;
        bit           stall_prev, last_prev;
        int           busy_cnt, gr, gi;
        real          dr, di;
        exp_t         e;
        stall_prev = 1'b0;
        last_prev  = 1'b0;
        busy_cnt   = 0;
        held       = '0;
        held_idx   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
                last_prev  = 1'b0;
                busy_cnt   = 0;
            end else begin
                if (stall_prev) begin
                    check("hold_data", bus.out_data == held,
                          $sformatf("%h", bus.out_data), $sformatf("%h", held));
                    check("hold_index", bus.out_index == held_idx,
                          $sformatf("%0d", bus.out_index), $sformatf("%0d", held_idx));
                end
                if (last_prev || finish) begin
                    check("finish_after_last", finish == last_prev,
                          $sformatf("%0b", finish), $sformatf("%0b", last_prev));
                    check("in_ready_at_finish", bus.in_ready == 1'b1,
                          $sformatf("%0b", bus.in_ready), "1");
                end
                if (finish) finish_cnt++;
                if (bus.out_valid)
                    check("in_ready_low_unload", bus.in_ready == 1'b0,
                          $sformatf("%0b", bus.in_ready), "0");
                if (busy) busy_cnt++;
                else if (busy_cnt != 0) begin
                    check("busy_cycles", busy_cnt == S * N / 2,
                          $sformatf("%0d", busy_cnt), $sformatf("%0d", S * N / 2));
                    busy_cnt = 0;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_bin", 1'b0, $sformatf("bin %0d", bus.out_index), "none");
                    end else begin
                        e  = sb.pop_front();
                        gr = int'($signed(bus.out_data.re));
                        gi = int'($signed(bus.out_data.im));
                        dr = real'(gr) - e.re;
                        di = real'(gi) - e.im;
                        check("bin_real", dr <= TOL && dr >= -TOL,
                              $sformatf("%0d (k=%0d)", gr, e.idx), $sformatf("%0.2f", e.re));
                        check("bin_imag", di <= TOL && di >= -TOL,
                              $sformatf("%0d (k=%0d)", gi, e.idx), $sformatf("%0.2f", e.im));
                        check("bin_index", int'(bus.out_index) == e.idx,
                              $sformatf("%0d", bus.out_index), $sformatf("%0d", e.idx));
                        check("bin_last", bus.out_last == (e.idx == N - 1),
                              $sformatf("%0b", bus.out_last), $sformatf("%0b", e.idx == N - 1));
                    end
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                held       = bus.out_data;
                held_idx   = bus.out_index;
                last_prev  = bus.out_valid && bus.out_ready && bus.out_last;
            end
        end
    end

    initial begin
        int guard;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_inverse = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready == 1'b1, $sformatf("%0b", bus.in_ready), "1");
        check("rst_out_valid", bus.out_valid == 1'b0, $sformatf("%0b", bus.out_valid), "0");
        check("rst_out_last", bus.out_last == 1'b0, $sformatf("%0b", bus.out_last), "0");
        check("rst_busy", busy == 1'b0, $sformatf("%0b", busy), "0");
        check("rst_finish", finish == 1'b0, $sformatf("%0b", finish), "0");
        check("rst_out_data", bus.out_data == '0, $sformatf("%h", bus.out_data), "0");
        check("rst_out_index", bus.out_index == '0, $sformatf("%0d", bus.out_index), "0");
        rst = 1'b0;

        for (int n = 0; n < N; n++) begin cur_re[n] = (n == 0) ? 256 : 0; cur_im[n] = 0; end
        run_frame(1'b0, 1'b1, 0);
        for (int n = 0; n < N; n++) begin cur_re[n] = 64; cur_im[n] = 0; end
        run_frame(1'b0, 1'b1, 0);
        for (int n = 0; n < N; n++) begin
            cur_re[n] = int'(512.0 * $cos(2.0 * PI * real'(n) / real'(N)));
            cur_im[n] = 0;
        end
        run_frame(1'b0, 1'b1, 0);
        run_frame(1'b1, 1'b1, 0);
        drain();

        rdy_mode = 1;
        fill_random();
        run_frame(1'($urandom_range(1, 0)), 1'b1, 0);
        drain();
        rdy_mode = 0;

        fill_random();
        run_frame(1'b0, 1'b0, 0);
        guard = 0;
        while (!busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("busy_timeout", 1'b0, "busy low", "busy high");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", bus.in_ready == 1'b1, $sformatf("%0b", bus.in_ready), "1");
        check("abort_busy", busy == 1'b0, $sformatf("%0b", busy), "0");
        check("abort_out_valid", bus.out_valid == 1'b0, $sformatf("%0b", bus.out_valid), "0");
        for (int n = 0; n < N; n++) begin cur_re[n] = (n == 0) ? 256 : 0; cur_im[n] = 0; end
        run_frame(1'b0, 1'b1, 0);
        drain();

        rdy_mode = 2;
        for (int f = 0; f < 4; f++) begin
            fill_random();
            run_frame(1'($urandom_range(1, 0)), 1'b1, 3);
        end
        drain();

        check("finish_count", finish_cnt == frames_exp,
              $sformatf("%0d", finish_cnt), $sformatf("%0d", frames_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
